// File: rtl/fetch_pc_pkg.sv
// Shared types and constants for the instruction-fetch PC sequencer.
package fetch_pc_pkg;

    localparam int unsigned PC_W        = 64;
    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned FLUSH_CNT_W = 3;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    // Redirect targets are word aligned on load.
    function automatic logic [PC_W-1:0] align_target(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_redirect_buffer.sv
// Holds one branch target seen while fetch is stalled; newest load wins,
// clear (trap or consume) has priority over load.
module pc_redirect_buffer
    import fetch_pc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [PC_W-1:0]   target_i,
    input  logic              clear_i,
    output logic [PC_W-1:0]   target_o,
    output logic              valid_o
);

    // Target register and pending flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_o <= '0;
            valid_o  <= 1'b0;
        end else if (clear_i) begin
            valid_o  <= 1'b0;
        end else if (load_i) begin
            target_o <= target_i;
            valid_o  <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Instruction-fetch PC sequencer: boot, +4 fetch, stall hold, branch/trap
// redirects with a FLUSH_CYCLES-long flush window.
// Optional macro PC_BOUND_WRAP_EN: sequential increments reaching IMEM_BYTES
// reload RESET_PC (redirect targets are never wrapped).
module fetch_pc_sequencer
    import fetch_pc_pkg::*;
#(
    parameter logic [63:0] RESET_PC     = 64'd0,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned IMEM_BYTES   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [63:0] branch_target_i,
    input  logic        trap_valid_i,
    input  logic [63:0] trap_vector_i,
    output logic [63:0] pc_o,
    output logic        fetch_valid_o,
    output logic        flush_o,
    output logic        redirect_pending_o
);

    // Reject parameter values the counter or memory map cannot represent.
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || IMEM_BYTES < INSTR_BYTES) begin : g_bad_params
        $error("fetch_pc_sequencer: FLUSH_CYCLES must be 1..7 and IMEM_BYTES >= 4");
    end

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    fetch_state_t           state_q, state_d;
    logic [PC_W-1:0]        pc_d;
    logic                   fetch_valid_d;
    logic                   flush_d;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]        pc_inc;
    logic                   redirect;
    logic [PC_W-1:0]        redirect_target;
    logic                   buf_load;
    logic                   buf_clear;
    logic [PC_W-1:0]        buf_target;

    pc_redirect_buffer u_redirect_buffer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (buf_load),
        .target_i (branch_target_i),
        .clear_i  (buf_clear),
        .target_o (buf_target),
        .valid_o  (redirect_pending_o)
    );

    // Sequential next fetch address.
    always_comb begin
        pc_inc = pc_o + PC_W'(INSTR_BYTES);
`ifdef PC_BOUND_WRAP_EN
        if (pc_inc >= PC_W'(IMEM_BYTES)) begin
            pc_inc = RESET_PC;
        end
`endif
    end

    // Next-state, next-PC and flush-window control.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_o;
        fetch_valid_d   = fetch_valid_o;
        flush_d         = flush_o;
        cnt_d           = cnt_q;
        redirect        = 1'b0;
        redirect_target = '0;
        buf_load        = 1'b0;
        buf_clear       = 1'b0;

        case (state_q)
            BOOT: begin
                fetch_valid_d = 1'b1;
                state_d       = RUN;
            end
            RUN: begin
                if (trap_valid_i) begin
                    redirect        = 1'b1;
                    redirect_target = trap_vector_i;
                end else if (branch_taken_i) begin
                    redirect        = 1'b1;
                    redirect_target = branch_target_i;
                end else if (stall_i) begin
                    state_d = STALL;
                end else begin
                    pc_d = pc_inc;
                end
            end
            STALL: begin
                if (trap_valid_i) begin
                    redirect        = 1'b1;
                    redirect_target = trap_vector_i;
                    buf_clear       = 1'b1;
                end else if (stall_i) begin
                    buf_load = branch_taken_i;
                end else if (branch_taken_i) begin
                    // Branch on the release cycle is newer than anything buffered.
                    redirect        = 1'b1;
                    redirect_target = branch_target_i;
                    buf_clear       = 1'b1;
                end else if (redirect_pending_o) begin
                    redirect        = 1'b1;
                    redirect_target = buf_target;
                    buf_clear       = 1'b1;
                end else begin
                    state_d = RUN;
                    pc_d    = pc_inc;
                end
            end
            FLUSH: begin
                if (trap_valid_i) begin
                    redirect        = 1'b1;
                    redirect_target = trap_vector_i;
                end else if (cnt_q == '0) begin
                    flush_d       = 1'b0;
                    fetch_valid_d = 1'b1;
                    state_d       = RUN;
                    pc_d          = pc_inc;
                end else begin
                    cnt_d = cnt_q - FLUSH_CNT_W'(1);
                    pc_d  = pc_inc;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // Every redirect opens a fresh flush window.
        if (redirect) begin
            pc_d          = align_target(redirect_target);
            state_d       = FLUSH;
            flush_d       = 1'b1;
            fetch_valid_d = 1'b0;
            cnt_d         = FLUSH_RELOAD;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_o          <= RESET_PC;
            fetch_valid_o <= 1'b0;
            flush_o       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pc_o          <= pc_d;
            fetch_valid_o <= fetch_valid_d;
            flush_o       <= flush_d;
            cnt_q         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed self-checking bench for fetch_pc_sequencer (FLUSH_CYCLES=2, IMEM_BYTES=16).
module tb_fetch_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        branch_taken_i;
    logic [63:0] branch_target_i;
    logic        trap_valid_i;
    logic [63:0] trap_vector_i;
    logic [63:0] pc_o;
    logic        fetch_valid_o;
    logic        flush_o;
    logic        redirect_pending_o;

    int tests_run = 0;
    int tests_failed = 0;

    fetch_pc_sequencer #(
        .RESET_PC     (64'd0),
        .FLUSH_CYCLES (2),
        .IMEM_BYTES   (16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .stall_i            (stall_i),
        .branch_taken_i     (branch_taken_i),
        .branch_target_i    (branch_target_i),
        .trap_valid_i       (trap_valid_i),
        .trap_vector_i      (trap_vector_i),
        .pc_o               (pc_o),
        .fetch_valid_o      (fetch_valid_o),
        .flush_o            (flush_o),
        .redirect_pending_o (redirect_pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected sequential increment for the selected build.
    function automatic logic [63:0] inc(input logic [63:0] x);
        logic [63:0] r;
        r = x + 64'd4;
`ifdef PC_BOUND_WRAP_EN
        if (r >= 64'd16) r = 64'd0;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [63:0] pc,
                             input logic fv, input logic fl, input logic pend);
        check({tag, ".pc"}, pc_o, pc);
        check({tag, ".fetch_valid"}, 64'(fetch_valid_o), 64'(fv));
        check({tag, ".flush"}, 64'(flush_o), 64'(fl));
        check({tag, ".pending"}, 64'(redirect_pending_o), 64'(pend));
    endtask

    logic [63:0] p;

    initial begin
        reset = 1'b1;
        stall_i = 1'b0;
        branch_taken_i = 1'b0;
        branch_target_i = '0;
        trap_valid_i = 1'b0;
        trap_vector_i = '0;

        // Reset held for 3 cycles.
        step(); step(); step();
        check_out("reset", 64'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Boot then sequential fetch.
        step(); check_out("boot", 64'd0, 1'b1, 1'b0, 1'b0);
        step(); check("seq1", pc_o, 64'd4);
        step(); check("seq2", pc_o, 64'd8);
        step(); check("seq3", pc_o, 64'd12);
`ifdef PC_BOUND_WRAP_EN
        step(); check("seq4", pc_o, 64'd0);
        step(); check("seq5", pc_o, 64'd4);
`else
        step(); check("seq4", pc_o, 64'd16);
        step(); check("seq5", pc_o, 64'd20);
`endif

        // Branch redirect with a two-cycle flush window.
        branch_taken_i = 1'b1; branch_target_i = 64'h40;
        step(); branch_taken_i = 1'b0;
        check_out("br0", 64'h40, 1'b0, 1'b1, 1'b0);
        p = inc(64'h40);
        step(); check_out("br1", p, 1'b0, 1'b1, 1'b0);
        p = inc(p);
        step(); check_out("br_run", p, 1'b1, 1'b0, 1'b0);
        p = inc(p);
        step(); check("br_run2", pc_o, p);

        // Stall 3 cycles; two branches buffered, newest wins on release.
        stall_i = 1'b1;
        step(); check_out("st0", p, 1'b1, 1'b0, 1'b0);
        branch_taken_i = 1'b1; branch_target_i = 64'h60;
        step(); check_out("st1", p, 1'b1, 1'b0, 1'b1);
        branch_target_i = 64'h80;
        step(); check_out("st2", p, 1'b1, 1'b0, 1'b1);
        branch_taken_i = 1'b0; stall_i = 1'b0;
        step(); check_out("st_rel", 64'h80, 1'b0, 1'b1, 1'b0);
        step(); check("st_fl1", 64'(flush_o), 64'd1);
        p = inc(inc(64'h80));
        step(); check_out("st_run", p, 1'b1, 1'b0, 1'b0);

        // Stall with a buffered branch, then trap: trap wins, buffer cleared.
        stall_i = 1'b1;
        step(); check("tr_st", pc_o, p);
        branch_taken_i = 1'b1; branch_target_i = 64'h80;
        step(); check_out("tr_pend", p, 1'b1, 1'b0, 1'b1);
        branch_taken_i = 1'b0; trap_valid_i = 1'b1; trap_vector_i = 64'h203;
        step(); check_out("tr0", 64'h200, 1'b0, 1'b1, 1'b0);
        trap_valid_i = 1'b0; stall_i = 1'b0;
        step(); check_out("tr1", inc(64'h200), 1'b0, 1'b1, 1'b0);

        // Trap in the last flush cycle restarts the window.
        trap_valid_i = 1'b1; trap_vector_i = 64'h300;
        step(); check_out("trf0", 64'h300, 1'b0, 1'b1, 1'b0);
        trap_valid_i = 1'b0;
        step(); check_out("trf1", inc(64'h300), 1'b0, 1'b1, 1'b0);
        p = inc(inc(64'h300));
        step(); check_out("trf_run", p, 1'b1, 1'b0, 1'b0);

        // Stall and branch are ignored during FLUSH.
        branch_taken_i = 1'b1; branch_target_i = 64'h100;
        step(); check("ign0", pc_o, 64'h100);
        branch_target_i = 64'h500; stall_i = 1'b1;
        step(); check_out("ign1", inc(64'h100), 1'b0, 1'b1, 1'b0);
        branch_taken_i = 1'b0; stall_i = 1'b0;
        p = inc(inc(64'h100));
        step(); check_out("ign_run", p, 1'b1, 1'b0, 1'b0);

        // Single-cycle stall with nothing pending: increment on release edge.
        stall_i = 1'b1;
        step(); check("st1c", pc_o, p);
        stall_i = 1'b0;
        step(); check("st1c_rel", pc_o, inc(p));

        // Asynchronous reset in the middle of a flush window.
        branch_taken_i = 1'b1; branch_target_i = 64'h44;
        step(); branch_taken_i = 1'b0;
        check("ar_pre", 64'(flush_o), 64'd1);
        #2 reset = 1'b1;
        #1 check_out("ar_async", 64'd0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        step(); check_out("ar_boot", 64'd0, 1'b1, 1'b0, 1'b0);
        step(); check_out("ar_run", 64'd4, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
